// File: rtl/spi_8bits_rx_pkg.sv
// Shared SPI types and widths; the master transmitter reuses DATA_W and BITCNT_W.
`timescale 1ns/1ps
package spi_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} spi_rx_state_t;
    localparam int DATA_W   = 8;
    localparam int BITCNT_W = 3;
endpackage

// File: rtl/spi_8bits_rx_if.sv
// Received-byte stream: holding register contents plus valid/ready handshake.
`timescale 1ns/1ps
interface spi_8bits_rx_if;
    import spi_pkg::*;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/spi_8bits_rx_sync.sv
// N-flop synchroniser for one asynchronous pin; reset value is a parameter.
`timescale 1ns/1ps
module spi_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [N-1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ff <= {N{RST_VAL}};
        else      ff <= {ff[N-2:0], d};
    end

    assign q = ff[N-1];
endmodule

// File: rtl/spi_8bits_rx.sv
// SPI mode-0 slave receiver: oversampled pins, 8-bit deserialiser, valid/ready holding register.
// Latency SYNC_STAGES+2 clk from 8th sclk rise to rx_valid; a full holding register drops the new byte (overrun).
`timescale 1ns/1ps
module spi_8bits_rx
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 cs,
    input  logic                 mosi,
    spi_8bits_rx_if.master       rx,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    logic sclk_s, cs_s, mosi_s, sclk_d, rise;

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .d(cs),   .q(cs_s));
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sclk_d <= 1'b0;
        else      sclk_d <= sclk_s;
    end

    assign rise = sclk_s & ~sclk_d;

    spi_rx_state_t        state;
    logic [BITCNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0]    shift_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            rx.rx_data  <= '0;
            rx.rx_valid <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            // A LOAD in this same cycle overrides this clear.
            if (rx.rx_valid && rx.rx_ready) rx.rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (!cs_s) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cs_s) begin
                        // cs wins over a coincident rise; any partial byte is discarded.
                        state     <= IDLE;
                        busy      <= 1'b0;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        frame_err <= (bit_cnt != '0);
                    end else if (rise) begin
                        shift_reg <= {shift_reg[DATA_W-2:0], mosi_s};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == BITCNT_W'(DATA_W - 1)) state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!rx.rx_valid || rx.rx_ready) begin
                        rx.rx_data  <= shift_reg;
                        rx.rx_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                    bit_cnt <= '0;
                    state   <= cs_s ? IDLE : SHIFT;
                    busy    <= ~cs_s;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
